pmem_arbiter: RTL
=================

PMEM_ARBITER -- requirements
Module: pmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter LINE_W, default 256, cache-line width.
REQ-003 SHALL have ports:
- clk  input  1  sole clock
- rst_n  input  1  synchronous, active-low reset
- i_pmem_read  input  1  L1I line-fill request
- i_pmem_address  input  ADDR_W  L1I line address
- i_pmem_rdata  output  LINE_W  line returned to L1I
- i_pmem_resp  output  1  L1I transfer done
- d_pmem_read  input  1  L1D line-fill request
- d_pmem_write  input  1  L1D write-back request
- d_pmem_address  input  ADDR_W  L1D line address
- d_pmem_wdata  input  LINE_W  L1D write-back line
- d_pmem_rdata  output  LINE_W  line returned to L1D
- d_pmem_resp  output  1  L1D transfer done
- pmem_read  output  1  downstream read
- pmem_write  output  1  downstream write
- pmem_address  output  ADDR_W  downstream address
- pmem_wdata  output  LINE_W  downstream write data
- pmem_rdata  input  LINE_W  downstream read data
- pmem_resp  input  1  downstream done
- conflict_clear  input  1  clear conflict_count
- conflict_count  output  32  cycles spent in IDLE with both requesters pending
- i_wait_count  output  32  cycles with i_pmem_read high and no I grant
REQ-004 SHALL use one clock; reset is synchronous and active-low.

Function
REQ-005 SHALL implement states IDLE, GRANT_I, GRANT_D.
REQ-006 IDLE: exactly one requester pending SHALL move to that requester's grant state next cycle.
REQ-007 IDLE: both pending SHALL grant the requester not served last (round-robin bit last_i), then toggle last_i on entry to the grant state.
REQ-008 d request SHALL be d_pmem_read | d_pmem_write; both asserted simultaneously SHALL be treated as write-only.
REQ-009 In GRANT_x, pmem_read, pmem_write, pmem_address and pmem_wdata SHALL combinationally follow the granted requester's inputs.
- I grant: pmem_write=0, pmem_wdata=0.
REQ-010 In IDLE, all pmem_* outputs SHALL be 0.
REQ-011 pmem_resp SHALL be routed only to the granted requester's *_resp in the same cycle; the other *_resp SHALL be 0.
REQ-012 pmem_rdata SHALL drive both *_rdata continuously.
REQ-013 GRANT_x SHALL return to IDLE on the cycle after pmem_resp=1.
- No back-to-back grant without one IDLE cycle, so requesters drop their request first.
REQ-014 If the granted request deasserts before pmem_resp, the arbiter SHALL return to IDLE next cycle.
- pmem_resp arriving outside a grant SHALL be ignored.
REQ-015 Latency: request seen in IDLE -> pmem_read/pmem_write high the following cycle.
REQ-016 Counters SHALL saturate at 32'hFFFF_FFFF and not wrap.
- conflict_clear SHALL have priority over increment.

Reset
REQ-017 rst_n=0 at a clk edge SHALL force state=IDLE, last_i=0 (I wins first conflict), both counters=0.
- Applies mid-grant; the downstream transaction is abandoned and no *_resp is issued.
REQ-018 All outputs SHALL be 0 in the cycle after reset is sampled.

Structure
REQ-019 State enum and ADDR_W/LINE_W defaults SHALL live in shared package arbiter_types.
REQ-020 Both counters SHALL reuse the existing counter sub-module, extended with saturation and rst_n.

Verification
REQ-021 Single I read at 0x0000_1000, pmem_resp after 3 cycles -> pmem_read=1 with address 0x1000; i_pmem_resp pulses once; d_pmem_resp stays 0.
REQ-022 I and D read raised in the same cycle after reset -> I granted first, D granted after one IDLE cycle; conflict_count=1.
REQ-023 Repeated simultaneous requests -> grants alternate I, D, I, D.
REQ-024 D read+write with wdata=0xA5.. -> pmem_write=1, pmem_read=0, pmem_wdata=0xA5...
REQ-025 rst_n low during GRANT_D, then released -> IDLE, no d_pmem_resp, counters 0.
REQ-026 Force i_wait_count to 32'hFFFF_FFFE and hold I waiting 3 cycles -> value stays 32'hFFFF_FFFF.

Source files
------------

// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the L1I/L1D physical-memory arbiter: FSM state encoding,
// default widths and the saturating-increment helper used by its counters.
package arbiter_types;

  localparam int          ADDR_W_DEF = 32;
  localparam int          LINE_W_DEF = 256;
  localparam logic [31:0] CNT_MAX    = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2
  } arb_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == CNT_MAX) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pmem_arbiter_counter.sv
// 32-bit event counter with synchronous active-low reset, clear and
// saturation at all-ones; clear wins over increment.
module pmem_arbiter_counter
  import arbiter_types::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = sat_inc(count_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between the L1I and
// L1D line-fill/write-back engines, with conflict and I-stall counters.
module pmem_arbiter
  import arbiter_types::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,

  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,

  input  logic              conflict_clear,
  output logic [31:0]       conflict_count,
  output logic [31:0]       i_wait_count
);

  arb_state_e state_q;
  arb_state_e state_d;
  logic       last_i_q;
  logic       last_i_d;

  logic i_req;
  logic d_req;
  logic conflict_inc;
  logic i_wait_inc;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  // last_i_q set means I won the most recent conflict, so D wins the next one.
  always_comb begin
    state_d  = state_q;
    last_i_d = last_i_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_req && d_req) begin
          state_d  = last_i_q ? ST_GRANT_D : ST_GRANT_I;
          last_i_d = ~last_i_q;
        end else if (i_req) begin
          state_d = ST_GRANT_I;
        end else if (d_req) begin
          state_d = ST_GRANT_D;
        end
      end
      ST_GRANT_I: begin
        if (pmem_resp || !i_req) state_d = ST_IDLE;
      end
      ST_GRANT_D: begin
        if (pmem_resp || !d_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      last_i_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_i_q <= last_i_d;
    end
  end

  // A simultaneous D read+write is a write-back only.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    unique case (state_q)
      ST_GRANT_I: begin
        pmem_read    = i_pmem_read;
        pmem_address = i_pmem_address;
        i_pmem_resp  = pmem_resp;
      end
      ST_GRANT_D: begin
        pmem_read    = d_pmem_read & ~d_pmem_write;
        pmem_write   = d_pmem_write;
        pmem_address = d_pmem_address;
        pmem_wdata   = d_pmem_wdata;
        d_pmem_resp  = pmem_resp;
      end
      default: ;
    endcase
  end

  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

  assign conflict_inc = (state_q == ST_IDLE) && i_req && d_req;
  assign i_wait_inc   = i_req && (state_q != ST_GRANT_I);

  pmem_arbiter_counter u_conflict_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (conflict_clear),
    .inc   (conflict_inc),
    .count (conflict_count)
  );

  pmem_arbiter_counter u_i_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (i_wait_inc),
    .count (i_wait_count)
  );

endmodule
